// File: rtl/crypt_pkg.sv
// Shared cipher package for the encrypter/decrypter pair: FSM states,
// byte and counter types, counter width.
package crypt_pkg;

  localparam int CTR_W = 8;

  typedef logic [7:0]       byte_t;
  typedef logic [CTR_W-1:0] ctr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/stream_decrypter_if.sv
// Byte-stream handshake bundle for stream_decrypter: ciphertext in
// (valid/ready) and plaintext out (valid/ready/last).
interface stream_decrypter_if;
  import crypt_pkg::*;

  logic  in_valid;
  byte_t in_data;
  logic  in_ready;
  logic  out_valid;
  byte_t out_data;
  logic  out_last;
  logic  out_ready;

  // Decrypter side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/stream_decrypter_byte_decrypter.sv
// Combinational byte decrypter: exact inverse of byte_encrypter
// (c = (p ^ key) + ctr), so p = (c - ctr) ^ key, all mod 256.
module byte_decrypter
  import crypt_pkg::*;
(
  input  byte_t cipher,
  input  byte_t key,
  input  ctr_t  ctr,
  output byte_t plain
);

  assign plain = byte_t'(cipher - ctr) ^ key;

endmodule

// File: rtl/stream_decrypter.sv
// stream_decrypter: recovers plaintext from a ciphertext byte stream, one
// byte per accepted beat, using counter (offset + byte index) mod 256.
// Registered valid/ready output stage with full backpressure.
// Optional feature: define STREAM_DECRYPTER_CHECKSUM_EN to add the
// `checksum` port (XOR of all plaintext bytes of the frame).
module stream_decrypter
  import crypt_pkg::*;
#(
  parameter int FRAME_LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  byte_t                  key,
  input  byte_t                  offset,
  input  logic [FRAME_LEN_W-1:0] frame_len,
  output logic                   busy,
  output logic                   done,
`ifdef STREAM_DECRYPTER_CHECKSUM_EN
  output byte_t                  checksum,
`endif
  stream_decrypter_if.slave      bus
);

  state_t                 state;
  state_t                 state_nxt;
  byte_t                  key_q;
  ctr_t                   ctr;
  logic [FRAME_LEN_W-1:0] remaining;

  byte_t out_data_q;
  logic  out_valid_q;
  logic  out_last_q;
  logic  done_q;

  byte_t plain;
  logic  in_ready_c;
  logic  launch;
  logic  accept;
  logic  drain_hs;
  logic  last_beat;
  logic  zero_len;

  assign launch    = (state == IDLE) && start;
  assign zero_len  = (frame_len == '0);
  assign accept    = bus.in_valid && in_ready_c;
  assign drain_hs  = out_valid_q && bus.out_ready;
  assign last_beat = (remaining == FRAME_LEN_W'(1));

  byte_decrypter u_byte_decrypter (
    .cipher (bus.in_data),
    .key    (key_q),
    .ctr    (ctr),
    .plain  (plain)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch && !zero_len) state_nxt = RUN;
      RUN:     if (accept && last_beat) state_nxt = DRAIN;
      DRAIN:   if (drain_hs)            state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // FSM outputs: input acceptance depends only on state, count and output stage
  always_comb begin
    in_ready_c = 1'b0;
    busy       = 1'b0;
    case (state)
      RUN: begin
        busy       = 1'b1;
        in_ready_c = (remaining != '0) && (!out_valid_q || bus.out_ready);
      end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  // Frame context: key, running counter and bytes still expected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q     <= '0;
      ctr       <= '0;
      remaining <= '0;
    end else if (launch && !zero_len) begin
      key_q     <= key;
      ctr       <= offset;
      remaining <= frame_len;
    end else if (accept) begin
      ctr       <= ctr + ctr_t'(1);
      remaining <= remaining - FRAME_LEN_W'(1);
    end
  end

  // Output register: a new beat wins over a drain so throughput stays 1/cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      out_data_q  <= plain;
      out_valid_q <= 1'b1;
      out_last_q  <= last_beat;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  // Completion pulse: empty frame launch, or last byte taken by the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= (launch && zero_len) || ((state == DRAIN) && drain_hs);
  end

`ifdef STREAM_DECRYPTER_CHECKSUM_EN
  byte_t checksum_q;

  // Running XOR of recovered plaintext; holds after done until the next launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      checksum_q <= '0;
    else if (launch) checksum_q <= '0;
    else if (accept) checksum_q <= checksum_q ^ plain;
  end

  assign checksum = checksum_q;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign done          = done_q;

endmodule
